// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one bitwise logic unit between NREQ requesters.
// Optional response timeout enabled by defining LU_ARB_TIMEOUT_EN.
module logic_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_op,
    output logic [DW-1:0]        lu_a,
    output logic [DW-1:0]        lu_b,
    output logic [1:0]           lu_op,
    input  logic [DW-1:0]        lu_y,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("logic_unit_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [IW-1:0]   grant_idx;
    logic            grant_found;
    logic            req_hs;
`ifdef LU_ARB_TIMEOUT_EN
    logic [7:0]      cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Rotating priority search starting just past the last winner.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IW'((int'(last_grant_q) + k) % NREQ);
            end
        end
    end

    assign req_hs = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            winner_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_data_q   <= '0;
`ifdef LU_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_data_q   <= rsp_data_d;
`ifdef LU_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
`ifdef LU_ARB_TIMEOUT_EN
        cnt_d         = '0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    a_d          = req_a[grant_idx*DW +: DW];
                    b_d          = req_b[grant_idx*DW +: DW];
                    op_d         = req_op[grant_idx*2 +: 2];
                    winner_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                rsp_data_d = lu_y;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready[winner_q]) begin
                    state_d = IDLE;
`ifdef LU_ARB_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Result is dropped; pointer already moved past this winner.
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        lu_a      = '0;
        lu_b      = '0;
        lu_op     = '0;
        rsp_valid = '0;
        busy      = (state_q != IDLE);
        rsp_data  = rsp_data_q;
        // Gated by rst_n so nothing is offered while reset is held.
        if (state_q == IDLE && grant_found && rst_n)
            req_ready = NREQ'(1) << grant_idx;
        if (state_q == ISSUE) begin
            lu_a  = a_q;
            lu_b  = b_q;
            lu_op = op_q;
        end
        if (state_q == RESP)
            rsp_valid = NREQ'(1) << winner_q;
    end

`ifdef LU_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter (default build, timeout feature off).
module tb_logic_unit_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0]   req_a, req_b;
    logic [NREQ*2-1:0]    req_op;
    logic [DW-1:0]        lu_a, lu_b, lu_y, rsp_data;
    logic [1:0]           lu_op;
    logic                 busy, timeout_err;

    typedef struct { int idx; logic [7:0] data; } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic_unit_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .lu_a(lu_a), .lu_b(lu_b),
        .lu_op(lu_op), .lu_y(lu_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [7:0] lu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Shared logic unit behaves as the real combinational block would.
    assign lu_y = lu_model(lu_a, lu_b, lu_op);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*2 +: 2]  = op;
    endtask

    task automatic push(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op);
        exp_t e;
        e.idx  = i;
        e.data = lu_model(a, b, op);
        sb.push_back(e);
    endtask

    // Waits (bounded) for a grant offer; returns the cycle it was seen.
    task automatic wait_grant(output int at);
        bit seen = 0;
        at = -1;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = 1;
                at   = cyc;
            end
        end
        if (!seen) chk("grant_wait_expired", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1;
        end
        if (!done) chk("drain_expired", 32'd1, 32'd0);
    endtask

    // Response monitor: every response handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && (rsp_valid & rsp_ready) != '0) begin
            exp_t e;
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.idx));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    initial begin
        int t, prev;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = NREQ'($urandom);
        rsp_ready = NREQ'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_lu", {14'd0, lu_op, lu_a, lu_b}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = '0; rsp_ready = '0;

        // Single request from requester 1
        @(posedge clk); #1;
        set_req(1, 8'hF0, 8'h3C, 2'b00);
        push(1, 8'hF0, 8'h3C, 2'b00);
        req_valid = 4'b0010; rsp_ready = 4'b0010;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h2);
        chk("single_busy_n", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_lu_a", 32'(lu_a), 32'hF0);
        chk("single_lu_b", 32'(lu_b), 32'h3C);
        chk("single_lu_op", 32'(lu_op), 32'd0);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h2);
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 32'd0);
        chk("single_data_hold", 32'(rsp_data), 32'h30);
        chk("idle_lu_a", 32'(lu_a), 32'd0);
        drain();

        // Round-robin from a fresh pointer
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'hA5, 8'h0F, 2'(i));
        foreach (exp_g[k]) push(exp_g[k], 8'hA5, 8'h0F, 2'(exp_g[k]));
        rsp_ready = 4'b1111; req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(t);
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_g[k]));
            if (k > 0) chk("rr_spacing", 32'(t - prev), 32'd3);
            prev = t;
        end
        @(posedge clk); #1; req_valid = '0;
        drain();

        // Backpressure on requester 2, others waiting behind it
        @(posedge clk); #1;
        set_req(2, 8'hC3, 8'h5A, 2'b10);
        push(2, 8'hC3, 8'h5A, 2'b10);
        req_valid = 4'b0100; rsp_ready = '0;
        wait_grant(t);
        chk("bp_grant2", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        set_req(3, 8'h12, 8'h34, 2'b01);
        push(3, 8'h12, 8'h34, 2'b01);
        req_valid = 4'b1111;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h4);
            chk("bp_rsp_data", 32'(rsp_data), 32'h99);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1; rsp_ready = 4'b0100;
        @(negedge clk);
        chk("simul_no_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h8);
        @(posedge clk); #1; req_valid = '0; rsp_ready = 4'b1111;
        drain();

        // Reset while a response is pending
        @(posedge clk); #1;
        set_req(3, 8'hFF, 8'h0F, 2'b11);
        req_valid = 4'b1000; rsp_ready = '0;
        wait_grant(t);
        chk("mid_grant3", 32'(req_ready), 32'h8);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_in_resp", 32'(rsp_valid), 32'h8);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req(0, 8'h3C, 8'h0F, 2'b10);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("mid_rst_no_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("mid_grant0", 32'(req_ready), 32'h1);
        push(0, 8'h3C, 8'h0F, 2'b10);
        rsp_ready = 4'b1111;
        @(posedge clk); #1; req_valid = '0;
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
